// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - op codes, FSM states and op decode for shifter_seq (SHIFTER_ROTATE_EN)
package shifter_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LSL  = 3'b001;
    localparam logic [2:0] OP_LSR  = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ASR  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Rotates count as shift ops only when the rotate datapath is built.
    function automatic logic is_shift_op(input logic [2:0] op);
        case (op)
            OP_LSL, OP_LSR, OP_ASR: is_shift_op = 1'b1;
`ifdef SHIFTER_ROTATE_EN
            OP_ROL, OP_ROR:         is_shift_op = 1'b1;
`endif
            default:                is_shift_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/shifter_seq_step.sv
// rtl/shifter_seq_step.sv - combinational one-bit shift/rotate step (rotates under SHIFTER_ROTATE_EN)
module shift_step
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        case (op)
            OP_LSL: out = {in[WIDTH-2:0], 1'b0};
            OP_LSR: out = {1'b0, in[WIDTH-1:1]};
            OP_ASR: out = {in[WIDTH-1], in[WIDTH-1:1]};
`ifdef SHIFTER_ROTATE_EN
            OP_ROL: out = {in[WIDTH-2:0], in[WIDTH-1]};
            OP_ROR: out = {in[0], in[WIDTH-1:1]};
`endif
            default: out = in;
        endcase
    end

endmodule

// File: rtl/shifter_seq.sv
// rtl/shifter_seq.sv - multi-cycle shifter with start/busy/done handshake (SHIFTER_ROTATE_EN)
module shifter_seq
    import shifter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [SHW-1:0]   shamt,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    logic [SHW-1:0]   cnt, cnt_n;
    logic [2:0]       op_q, op_n;
    logic [WIDTH-1:0] d_n;
    logic             done_n;
    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_in, step_out;

    // The single step unit works on the fresh operand at accept and on d_out while iterating.
    assign step_op = (state == ST_SHIFT) ? op_q  : op;
    assign step_in = (state == ST_SHIFT) ? d_out : d_in;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op  (step_op),
        .in  (step_in),
        .out (step_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= OP_NOP;
            d_out <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            d_out <= d_n;
            done  <= done_n;
        end
    end

    assign busy = (state == ST_SHIFT);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        d_n     = d_out;
        done_n  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    op_n = op;
                    if (op == OP_LOAD) begin
                        d_n    = d_in;
                        done_n = 1'b1;
                    end else if (is_shift_op(op)) begin
                        if (shamt == '0) begin
                            d_n    = d_in;
                            done_n = 1'b1;
                        end else begin
                            d_n = step_out;
                            if (shamt == SHW'(1)) begin
                                done_n = 1'b1;
                            end else begin
                                state_n = ST_SHIFT;
                                cnt_n   = shamt - SHW'(1);
                            end
                        end
                    end else begin
                        done_n = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                d_n   = step_out;
                cnt_n = cnt - SHW'(1);
                if (cnt == SHW'(1)) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_shifter_seq.sv
// tb/tb_shifter_seq.sv - scoreboard bench for shifter_seq, WIDTH=8 (honours SHIFTER_ROTATE_EN)
module tb_shifter_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [2:0] shamt;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       busy;
    logic       done;

    int         vectors = 0;
    int         miscompares = 0;
    int         busy_cnt = 0;
    logic [7:0] sb[$];

    shifter_seq #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .shamt (shamt),
        .d_in  (d_in),
        .d_out (d_out),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expected result.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            if (sb.size() == 0) check("spurious_done", 32'(d_out), 32'hDEAD);
            else check("sb_result", 32'(d_out), 32'(sb.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [2:0] k, input logic [7:0] din,
                          input logic [7:0] exp, input int lat, input int busy_exp);
        int n;
        start = 1'b1; op = o; shamt = k; d_in = din;
        sb.push_back(exp);
        busy_cnt = 0;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("busy_cycles", 32'(busy_cnt), 32'(busy_exp));
        tick();
        check("done_one_shot", 32'(done), 32'd0);
        check("hold_after_done", 32'(d_out), 32'(exp));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'b000; shamt = 3'd0; d_in = 8'h00;
        tick();
        tick();
        check("rst_d_out", 32'(d_out), 32'h00);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();

        run_op(3'b111, 3'd5, 8'h0F, 8'h0F, 1, 0);

        // LSL by 2 with intermediate value checks
        start = 1'b1; op = 3'b001; shamt = 3'd2; d_in = 8'hFF;
        sb.push_back(8'hFC);
        busy_cnt = 0;
        tick();
        start = 1'b0; d_in = 8'h00;
        check("lsl_e0", 32'(d_out), 32'hFE);
        check("lsl_e0_busy", 32'(busy), 32'd1);
        check("lsl_e0_done", 32'(done), 32'd0);
        tick();
        check("lsl_e1", 32'(d_out), 32'hFC);
        check("lsl_e1_done", 32'(done), 32'd1);
        check("lsl_busy_cycles", 32'(busy_cnt), 32'd1);
        tick();

        // ASR by 3 with an ignored LOAD request mid-operation
        start = 1'b1; op = 3'b100; shamt = 3'd3; d_in = 8'h80;
        sb.push_back(8'hF0);
        tick();
        check("asr_e0", 32'(d_out), 32'hC0);
        op = 3'b111; d_in = 8'h55;
        tick();
        start = 1'b0;
        check("asr_e1", 32'(d_out), 32'hE0);
        check("asr_e1_busy", 32'(busy), 32'd1);
        tick();
        check("asr_e2", 32'(d_out), 32'hF0);
        check("asr_e2_done", 32'(done), 32'd1);
        tick();
        check("asr_ignored_load", 32'(d_out), 32'hF0);
        check("asr_done_pulse", 32'(done), 32'd0);

`ifdef SHIFTER_ROTATE_EN
        run_op(3'b101, 3'd1, 8'h01, 8'h80, 1, 0);
        run_op(3'b011, 3'd3, 8'h81, 8'h0C, 3, 2);
`else
        run_op(3'b101, 3'd1, 8'h01, 8'hF0, 1, 0);
        run_op(3'b011, 3'd3, 8'h81, 8'hF0, 1, 0);
`endif
        run_op(3'b010, 3'd0, 8'h3C, 8'h3C, 1, 0);
        run_op(3'b000, 3'd4, 8'h99, 8'h3C, 1, 0);
        run_op(3'b110, 3'd4, 8'h99, 8'h3C, 1, 0);
        run_op(3'b100, 3'd7, 8'h7F, 8'h00, 7, 6);

        // LSR by 7 aborted by reset; no done pulse is expected
        start = 1'b1; op = 3'b010; shamt = 3'd7; d_in = 8'hFF;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check("abort_d_out", 32'(d_out), 32'h00);
        check("abort_busy_low", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        reset = 1'b0;
        tick();
        run_op(3'b111, 3'd0, 8'hA5, 8'hA5, 1, 0);

        // reset and start on the same edge: start dropped
        reset = 1'b1; start = 1'b1; op = 3'b111; d_in = 8'h33;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_start_d_out", 32'(d_out), 32'h00);
        tick();
        check("rst_start_done", 32'(done), 32'd0);

        // start held high: back-to-back LOADs
        start = 1'b1; op = 3'b111; d_in = 8'h11; sb.push_back(8'h11);
        tick();
        d_in = 8'h22; sb.push_back(8'h22);
        tick();
        check("b2b_done1", 32'(done), 32'd1);
        d_in = 8'h33; sb.push_back(8'h33);
        tick();
        start = 1'b0;
        check("b2b_d_out", 32'(d_out), 32'h33);
        tick();
        tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shifter_seq.md
# shifter_seq

Parametrised, multi-cycle successor to the 8-bit register shifter. It loads a WIDTH-bit word, then shifts or rotates it one bit position per clock for `shamt` cycles. A start/busy/done handshake lets a controller issue one operation at a time. The block sits in the datapath between the operand register file and the result bus, with its output registered.

## Interface
- `WIDTH`, default 8: data width, must be ≥ 2.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width; derived, do not override.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a new operation; sampled only in IDLE.
- `op` in 3: operation code, captured when start is accepted.
- `shamt` in SHW: shift amount, 0..WIDTH-1, captured when start is accepted.
- `d_in` in WIDTH: operand, captured when start is accepted.
- `d_out` out WIDTH: result register.
- `busy` out 1: high while in SHIFT.
- `done` out 1: one-cycle pulse per accepted operation.

## Operation
- Op codes:
  - 000 NOP
  - 001 LSL (zero fill)
  - 010 LSR (zero fill)
  - 011 ROL
  - 100 ASR (MSB fill)
  - 101 ROR
  - 110 reserved, behaves as NOP
  - 111 LOAD
- States:
  - IDLE: accept start.
  - SHIFT: iterate; holds the remaining count `cnt` (SHW bits).
- Accept: `start`=1 in IDLE at edge E0 latches `op`, `shamt` and `d_in` internally. Later changes on those inputs are ignored until the next accept.
- NOP or reserved: `d_out` holds, `done`=1 after E0, state stays IDLE.
- LOAD: `d_out`←`d_in` at E0, `done`=1 after E0. `shamt` is ignored.
- Shift/rotate with shamt=0: `d_out`←`d_in` at E0, `done`=1 after E0, no SHIFT entry.
- Shift/rotate with shamt=k>0:
  - At E0: `d_out`←step(`d_in`).
  - If k=1: `done`=1 after E0 and stay in IDLE.
  - Otherwise: go to SHIFT with `cnt`=k-1.
  - Each edge in SHIFT: `d_out`←step(`d_out`) and `cnt`-1. The edge where `cnt`=1 returns to IDLE and sets `done`=1.
- `start` while busy: ignored, no queuing, no error.
- `start` held high in IDLE: accepted again on the edge after `done` is asserted, so back-to-back operations are allowed.
- Arithmetic: one-bit step per edge, no carry or overflow output. Rotate preserves all WIDTH bits.

## Timing
- Reset values: `d_out`=0, `busy`=0, `done`=0, state=IDLE, `cnt`=0.
- Reset mid-operation: reset dominates at the next edge, producing the reset values. The aborted operation yields no done pulse.
- `reset` and `start` on the same edge: reset wins and start is dropped.
- Latency, shamt=k≥1: final result and `done` are visible k cycles after the accept edge (inclusive of E0). `busy` is high for k-1 cycles.
- Latency, LOAD/NOP/k=0: result and `done` are visible 1 cycle after accept. `busy` never rises.
- `d_out` is stable whenever `done`=1 and remains unchanged in IDLE until the next accept.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SHIFTER_ROTATE_EN` defined: ROL (011) and ROR (101) are implemented as described.
- Not defined: 011 and 101 decode as reserved and behave as NOP (`done` pulse, `d_out` held). The rotate datapath is removed.

## Structure
- Package `shifter_pkg` holds:
  - The op-code localparams `OP_NOP`, `OP_LSL`, `OP_LSR`, `OP_ROL`, `OP_ASR`, `OP_ROR`, `OP_LOAD`.
  - The state enum {`ST_IDLE`, `ST_SHIFT`}.
- Sub-module `shift_step`: combinational one-bit step (`op`, `WIDTH`-bit in → out), instantiated once. Rotate cases are guarded by `SHIFTER_ROTATE_EN`.
- Top level contains the FSM, the counter, the latched op and the `d_out` register.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold `reset`=1 for 2 cycles → `d_out`=0x00, `busy`=0, `done`=0.
- LOAD with `d_in`=0x0F → `d_out`=0x0F and `done`=1 one cycle later, `busy` never high.
- LSL, shamt=2, `d_in`=0xFF → 0xFE after E0, then 0xFC with `done`=1 after E1, `busy`=1 for exactly one cycle.
- ASR, shamt=3, `d_in`=0x80 → 0xC0, 0xE0, 0xF0, with `done` on the third cycle. Issuing `start` with LOAD 0x55 mid-operation is ignored and the result stays 0xF0.
- ROR, shamt=1, `d_in`=0x01 → 0x80 with `done` when `SHIFTER_ROTATE_EN` is defined. Without the macro → `d_out` held and `done` pulse only.
- LSR, shamt=7, `d_in`=0xFF, with `reset` asserted after 3 cycles → `d_out`=0x00 and no `done` pulse. A subsequent LOAD 0xA5 completes normally.
